// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control_if
//  Description : Opcode/flag inputs and datapath control bundle of the
//                multi-cycle controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface multi_cycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic [2:0]  nowState;
    logic        PCWre;
    logic        IRWre;
    logic        ALUSrcB;
    logic        ALUM2Reg;
    logic        RegWre;
    logic        InsMemRW;
    logic        DataMemRW;
    logic        WrRegData;
    logic [1:0]  ExtSel;
    logic [1:0]  PCSrc;
    logic [1:0]  RegOut;
    logic [2:0]  ALUOp;
    logic [31:0] instCount;

    // Master supplies instruction bits and flags; slave is the controller.
    modport master (
        output opcode, zero,
        input  nowState, PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW,
               DataMemRW, WrRegData, ExtSel, PCSrc, RegOut, ALUOp, instCount
    );

    modport slave (
        input  opcode, zero,
        output nowState, PCWre, IRWre, ALUSrcB, ALUM2Reg, RegWre, InsMemRW,
               DataMemRW, WrRegData, ExtSel, PCSrc, RegOut, ALUOp, instCount
    );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multi_cycle_control
//  Description : Multi-cycle CPU control FSM with retired-instruction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_cycle_control #(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    multi_cycle_control_if.slave  bus
);

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000001;
    localparam logic [5:0] c_OP_ADDI = 6'b000010;
    localparam logic [5:0] c_OP_OR   = 6'b010000;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_ORI  = 6'b010010;
    localparam logic [5:0] c_OP_SW   = 6'b110000;
    localparam logic [5:0] c_OP_LW   = 6'b110001;
    localparam logic [5:0] c_OP_BEQ  = 6'b110100;
    localparam logic [5:0] c_OP_J    = 6'b111000;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t      state_q, state_d;
    logic        halted_q, halted_d;
    logic [31:0] inst_count_q, inst_count_d;

    logic        w_is_rtype;
    logic        w_is_itype;
    logic        w_is_mem;
    logic        w_pc_wre;
    logic        w_ir_wre;
    logic        w_alu_src_b;
    logic        w_alu_m2reg;
    logic        w_reg_wre;
    logic        w_ins_mem_rw;
    logic        w_data_mem_rw;
    logic        w_wr_reg_data;
    logic [1:0]  w_ext_sel;
    logic [1:0]  w_pc_src;
    logic [1:0]  w_reg_out;
    logic [2:0]  w_alu_op;

    assign w_is_rtype = (bus.opcode == c_OP_ADD) || (bus.opcode == c_OP_SUB) ||
                        (bus.opcode == c_OP_OR)  || (bus.opcode == c_OP_AND);
    assign w_is_itype = (bus.opcode == c_OP_ADDI) || (bus.opcode == c_OP_ORI);
    assign w_is_mem   = (bus.opcode == c_OP_SW) || (bus.opcode == c_OP_LW);

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        w_pc_wre      = 1'b0;
        w_ir_wre      = 1'b0;
        w_alu_src_b   = 1'b0;
        w_alu_m2reg   = 1'b0;
        w_reg_wre     = 1'b0;
        w_ins_mem_rw  = 1'b0;
        w_data_mem_rw = 1'b0;
        w_wr_reg_data = 1'b0;
        w_ext_sel     = 2'b00;
        w_pc_src      = 2'b00;
        w_reg_out     = 2'b00;
        w_alu_op      = 3'b000;

        case (state_q)
            S_IF: begin
                w_ir_wre     = 1'b1;
                w_ins_mem_rw = 1'b1;
                state_d      = S_ID;
            end
            S_ID: begin
                // Once halted, the opcode is ignored until reset.
                if (halted_q || (bus.opcode == HALT_OP)) begin
                    halted_d = 1'b1;
                    state_d  = S_ID;
                end else if (w_is_rtype || w_is_itype) begin
                    state_d = S_EXE_AL;
                end else if (w_is_mem) begin
                    state_d = S_EXE_LS;
                end else if (bus.opcode == c_OP_BEQ) begin
                    state_d = S_EXE_BR;
                end else if (bus.opcode == c_OP_J) begin
                    w_pc_wre = 1'b1;
                    w_pc_src = 2'b11;
                    state_d  = S_IF;
                end else begin
                    w_pc_wre = 1'b1;
                    state_d  = S_IF;
                end
            end
            S_EXE_AL: begin
                case (bus.opcode)
                    c_OP_SUB:           w_alu_op = 3'b001;
                    c_OP_OR, c_OP_ORI:  w_alu_op = 3'b011;
                    c_OP_AND:           w_alu_op = 3'b100;
                    default:            w_alu_op = 3'b000;
                endcase
                w_alu_src_b = w_is_itype;
                w_ext_sel   = (bus.opcode == c_OP_ADDI) ? 2'b01 : 2'b00;
                state_d     = S_WB_AL;
            end
            S_WB_AL: begin
                w_reg_wre     = 1'b1;
                w_wr_reg_data = 1'b1;
                w_reg_out     = w_is_rtype ? 2'b10 : 2'b01;
                w_pc_wre      = 1'b1;
                state_d       = S_IF;
            end
            S_EXE_BR: begin
                w_alu_op  = 3'b001;
                w_ext_sel = 2'b01;
                w_pc_wre  = 1'b1;
                w_pc_src  = bus.zero ? 2'b01 : 2'b00;
                state_d   = S_IF;
            end
            S_EXE_LS: begin
                w_alu_src_b = 1'b1;
                w_ext_sel   = 2'b01;
                state_d     = S_MEM;
            end
            S_MEM: begin
                if (bus.opcode == c_OP_SW) begin
                    w_data_mem_rw = 1'b1;
                    w_pc_wre      = 1'b1;
                    state_d       = S_IF;
                end else begin
                    state_d = S_WB_LD;
                end
            end
            S_WB_LD: begin
                w_reg_wre     = 1'b1;
                w_alu_m2reg   = 1'b1;
                w_wr_reg_data = 1'b1;
                w_reg_out     = 2'b01;
                w_pc_wre      = 1'b1;
                state_d       = S_IF;
            end
            default: state_d = S_IF;
        endcase

        inst_count_d = w_pc_wre ? (inst_count_q + 32'd1) : inst_count_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IF;
            halted_q     <= 1'b0;
            inst_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            inst_count_q <= inst_count_d;
        end
    end

    // Every output reads zero while reset is held.
    assign bus.nowState  = RST ? 3'b000 : state_q;
    assign bus.PCWre     = RST ? 1'b0   : w_pc_wre;
    assign bus.IRWre     = RST ? 1'b0   : w_ir_wre;
    assign bus.ALUSrcB   = RST ? 1'b0   : w_alu_src_b;
    assign bus.ALUM2Reg  = RST ? 1'b0   : w_alu_m2reg;
    assign bus.RegWre    = RST ? 1'b0   : w_reg_wre;
    assign bus.InsMemRW  = RST ? 1'b0   : w_ins_mem_rw;
    assign bus.DataMemRW = RST ? 1'b0   : w_data_mem_rw;
    assign bus.WrRegData = RST ? 1'b0   : w_wr_reg_data;
    assign bus.ExtSel    = RST ? 2'b00  : w_ext_sel;
    assign bus.PCSrc     = RST ? 2'b00  : w_pc_src;
    assign bus.RegOut    = RST ? 2'b00  : w_reg_out;
    assign bus.ALUOp     = RST ? 3'b000 : w_alu_op;
    assign bus.instCount = RST ? 32'd0  : inst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_cycle_control
//  Description : Scoreboard bench for multi_cycle_control, directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_cycle_control;

    // Strobe order: PCWre IRWre ALUSrcB ALUM2Reg RegWre InsMemRW DataMemRW WrRegData
    localparam logic [7:0] SB_NONE = 8'b0000_0000;
    localparam logic [7:0] SB_IF   = 8'b0100_0100;
    localparam logic [7:0] SB_PC   = 8'b1000_0000;
    localparam logic [7:0] SB_SRCB = 8'b0010_0000;
    localparam logic [7:0] SB_WBAL = 8'b1000_1001;
    localparam logic [7:0] SB_SW   = 8'b1000_0010;
    localparam logic [7:0] SB_WBLD = 8'b1001_1001;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_UND  = 6'b000011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct {
        string       tag;
        logic [51:0] v;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multi_cycle_control_if bus();

    multi_cycle_control #(.HALT_OP(OP_HALT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [51:0] ev(input logic [2:0] st, input logic [7:0] sb,
                                       input logic [1:0] ext, input logic [1:0] pcs,
                                       input logic [1:0] ro, input logic [2:0] alu,
                                       input logic [31:0] cnt);
        return {st, sb, ext, pcs, ro, alu, cnt};
    endfunction

    function automatic logic [51:0] actual();
        return {bus.nowState, bus.PCWre, bus.IRWre, bus.ALUSrcB, bus.ALUM2Reg,
                bus.RegWre, bus.InsMemRW, bus.DataMemRW, bus.WrRegData,
                bus.ExtSel, bus.PCSrc, bus.RegOut, bus.ALUOp, bus.instCount};
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic z,
                        input string tag, input logic [51:0] v);
        @(posedge CLK);
        #1;
        RST        = rst;
        bus.opcode = op;
        bus.zero   = z;
        sb_q.push_back('{tag, v});
    endtask

    task automatic alu_instr(input logic [5:0] op, input logic z, input string tag,
                             input logic [7:0] exe_sb, input logic [1:0] ext,
                             input logic [2:0] aluop, input logic [1:0] ro,
                             input logic [31:0] cnt);
        step(1'b0, op, z, {tag, "_IF"},  ev(3'b000, SB_IF,   2'b00, 2'b00, 2'b00, 3'b000, cnt));
        step(1'b0, op, z, {tag, "_ID"},  ev(3'b001, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, cnt));
        step(1'b0, op, z, {tag, "_EXE"}, ev(3'b110, exe_sb,  ext,   2'b00, 2'b00, aluop,  cnt));
        step(1'b0, op, z, {tag, "_WB"},  ev(3'b111, SB_WBAL, 2'b00, 2'b00, ro,    3'b000, cnt));
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic z, input string tag,
                                input logic [31:0] cnt);
        step(1'b0, op, z, {tag, "_IF"}, ev(3'b000, SB_IF,   2'b00, 2'b00, 2'b00, 3'b000, cnt));
        step(1'b0, op, z, {tag, "_ID"}, ev(3'b001, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, cnt));
    endtask

    // Monitor: compare one expected record per cycle on the falling edge.
    initial begin
        exp_t e;
        logic [51:0] a;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = actual();
                n_checks++;
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got state=%b strobes=%b ext=%b pcsrc=%b regout=%b aluop=%b cnt=%h, expected state=%b strobes=%b ext=%b pcsrc=%b regout=%b aluop=%b cnt=%h",
                             e.tag, a[51:49], a[48:41], a[40:39], a[38:37], a[36:35], a[34:32], a[31:0],
                             e.v[51:49], e.v[48:41], e.v[40:39], e.v[38:37], e.v[36:35], e.v[34:32], e.v[31:0]);
                end
            end
        end
    end

    initial begin
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;

        step(1'b1, OP_ADD, 1'b0, "reset", ev(3'b000, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd0));

        // ALU group; zero held high on add to show it has no effect there
        alu_instr(OP_ADD,  1'b1, "add",  SB_NONE, 2'b00, 3'b000, 2'b10, 32'd0);
        alu_instr(OP_SUB,  1'b0, "sub",  SB_NONE, 2'b00, 3'b001, 2'b10, 32'd1);
        alu_instr(OP_ADDI, 1'b0, "addi", SB_SRCB, 2'b01, 3'b000, 2'b01, 32'd2);
        alu_instr(OP_ORI,  1'b0, "ori",  SB_SRCB, 2'b00, 3'b011, 2'b01, 32'd3);
        alu_instr(OP_AND,  1'b0, "and",  SB_NONE, 2'b00, 3'b100, 2'b10, 32'd4);

        fetch_decode(OP_LW, 1'b0, "lw", 32'd5);
        step(1'b0, OP_LW, 1'b0, "lw_EXE", ev(3'b010, SB_SRCB, 2'b01, 2'b00, 2'b00, 3'b000, 32'd5));
        step(1'b0, OP_LW, 1'b0, "lw_MEM", ev(3'b011, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd5));
        step(1'b0, OP_LW, 1'b0, "lw_WB",  ev(3'b100, SB_WBLD, 2'b00, 2'b00, 2'b01, 3'b000, 32'd5));

        fetch_decode(OP_SW, 1'b0, "sw", 32'd6);
        step(1'b0, OP_SW, 1'b0, "sw_EXE", ev(3'b010, SB_SRCB, 2'b01, 2'b00, 2'b00, 3'b000, 32'd6));
        step(1'b0, OP_SW, 1'b0, "sw_MEM", ev(3'b011, SB_SW,   2'b00, 2'b00, 2'b00, 3'b000, 32'd6));

        fetch_decode(OP_BEQ, 1'b1, "beq1", 32'd7);
        step(1'b0, OP_BEQ, 1'b1, "beq1_EXE", ev(3'b101, SB_PC, 2'b01, 2'b01, 2'b00, 3'b001, 32'd7));
        fetch_decode(OP_BEQ, 1'b0, "beq0", 32'd8);
        step(1'b0, OP_BEQ, 1'b0, "beq0_EXE", ev(3'b101, SB_PC, 2'b01, 2'b00, 2'b00, 3'b001, 32'd8));

        step(1'b0, OP_J, 1'b0, "j_IF", ev(3'b000, SB_IF, 2'b00, 2'b00, 2'b00, 3'b000, 32'd9));
        step(1'b0, OP_J, 1'b0, "j_ID", ev(3'b001, SB_PC, 2'b00, 2'b11, 2'b00, 3'b000, 32'd9));

        step(1'b0, OP_UND, 1'b0, "und_IF", ev(3'b000, SB_IF, 2'b00, 2'b00, 2'b00, 3'b000, 32'd10));
        step(1'b0, OP_UND, 1'b0, "und_ID", ev(3'b001, SB_PC, 2'b00, 2'b00, 2'b00, 3'b000, 32'd10));

        // sw abandoned by reset in its MEM cycle
        fetch_decode(OP_SW, 1'b0, "swabort", 32'd11);
        step(1'b0, OP_SW, 1'b0, "swabort_EXE", ev(3'b010, SB_SRCB, 2'b01, 2'b00, 2'b00, 3'b000, 32'd11));
        step(1'b1, OP_SW, 1'b0, "swabort_RST", ev(3'b000, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd0));
        step(1'b0, OP_J,  1'b0, "postrst_IF",  ev(3'b000, SB_IF,   2'b00, 2'b00, 2'b00, 3'b000, 32'd0));
        step(1'b0, OP_J,  1'b0, "postrst_ID",  ev(3'b001, SB_PC,   2'b00, 2'b11, 2'b00, 3'b000, 32'd0));

        // Halt holds ID, even after the opcode changes away from HALT_OP
        step(1'b0, OP_HALT, 1'b0, "halt_IF", ev(3'b000, SB_IF, 2'b00, 2'b00, 2'b00, 3'b000, 32'd1));
        for (int i = 0; i < 10; i++)
            step(1'b0, OP_HALT, 1'b0, "halt_ID", ev(3'b001, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd1));
        for (int i = 0; i < 3; i++)
            step(1'b0, OP_ADD, 1'b1, "halt_hold", ev(3'b001, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd1));

        // Counter wrap: preset the counter, retire one j
        step(1'b1, OP_J, 1'b0, "wrap_RST", ev(3'b000, SB_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 32'd0));
        step(1'b0, OP_J, 1'b0, "wrap_IF",  ev(3'b000, SB_IF,   2'b00, 2'b00, 2'b00, 3'b000, 32'hFFFF_FFFF));
        force dut.inst_count_q = 32'hFFFF_FFFF;
        step(1'b0, OP_J, 1'b0, "wrap_ID",  ev(3'b001, SB_PC,   2'b00, 2'b11, 2'b00, 3'b000, 32'hFFFF_FFFF));
        release dut.inst_count_q;
        step(1'b0, OP_J, 1'b0, "wrap_after", ev(3'b000, SB_IF, 2'b00, 2'b00, 2'b00, 3'b000, 32'd0));

        for (int i = 0; i < 5 && sb_q.size() > 0; i++)
            @(posedge CLK);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d records left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
